// File: rtl/pc_seq_if.sv
// Command/status bundle between the nopCPU control unit and the program sequencer.
// valid/ready: none; every command is a one-cycle level sampled on each rising clk edge.
interface pc_seq_if #(
    parameter int AW    = 8,
    parameter int DEPTH = 4
);
    logic                         interrupt;
    logic                         freeze;
    logic                         jump;
    logic                         call;
    logic                         ret;
    logic                         reti;
    logic [AW-1:0]                jump_addr;
    logic [AW-1:0]                pc;
    logic                         irq_ack;
    logic                         in_isr;
    logic [$clog2(DEPTH+1)-1:0]   depth;
    logic                         ovf;
    logic                         unf;

    modport master (
        output interrupt, freeze, jump, call, ret, reti, jump_addr,
        input  pc, irq_ack, in_isr, depth, ovf, unf
    );

    modport slave (
        input  interrupt, freeze, jump, call, ret, reti, jump_addr,
        output pc, irq_ack, in_isr, depth, ovf, unf
    );
endinterface

// File: rtl/pc_seq.sv
// Program sequencer: PC with a circular hardware return stack (CALL/RET)
// and single-level vectored interrupt entry/RETI.
module pc_seq #(
    parameter int            AW        = 8,
    parameter int            DEPTH     = 4,
    parameter logic [AW-1:0] RESET_VEC = '0,
    parameter logic [AW-1:0] IRQ_VEC   = AW'('hF0)
) (
    input  logic     clk,
    input  logic     reset,
    pc_seq_if.slave  bus
);
    localparam int DW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);

    logic [AW-1:0] r_pc;
    logic [PW-1:0] r_wp;
    logic [DW-1:0] r_depth;
    logic          r_in_isr;
    logic          r_irq_ack;
    logic          r_ovf;
    logic          r_unf;
    logic [AW-1:0] r_mem [DEPTH];

    logic          w_take_irq;
    logic          w_push;
    logic          w_pop;
    logic          w_clr_isr;
    logic [AW-1:0] w_push_val;
    logic [AW-1:0] w_next_pc;
    logic [AW-1:0] w_pc_inc;
    logic [PW-1:0] w_wp_inc;
    logic [PW-1:0] w_wp_dec;
    logic          w_full;
    logic          w_empty;

    assign w_pc_inc = r_pc + AW'(1);
    assign w_wp_inc = (r_wp == PW'(DEPTH - 1)) ? '0 : r_wp + PW'(1);
    assign w_wp_dec = (r_wp == '0) ? PW'(DEPTH - 1) : r_wp - PW'(1);
    assign w_full   = (r_depth == DW'(DEPTH));
    assign w_empty  = (r_depth == '0);

    // Priority chain: freeze > interrupt entry > jump > call > ret > reti > increment.
    always_comb begin
        w_take_irq = 1'b0;
        w_push     = 1'b0;
        w_pop      = 1'b0;
        w_clr_isr  = 1'b0;
        w_push_val = r_pc;
        w_next_pc  = w_pc_inc;
        if (bus.freeze) begin
            w_next_pc = r_pc;
        end else if (bus.interrupt && !r_in_isr) begin
            w_take_irq = 1'b1;
            w_push     = 1'b1;
            w_next_pc  = IRQ_VEC;
        end else if (bus.jump) begin
            w_next_pc = bus.jump_addr;
        end else if (bus.call) begin
            w_push     = 1'b1;
            w_push_val = w_pc_inc;
            w_next_pc  = bus.jump_addr;
        end else if (bus.ret) begin
            w_pop = 1'b1;
        end else if (bus.reti) begin
            w_pop     = 1'b1;
            w_clr_isr = 1'b1;
        end
        // An empty-stack pop falls through to the default increment.
        if (w_pop && !w_empty) begin
            w_next_pc = r_mem[w_wp_dec];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc      <= RESET_VEC;
            r_wp      <= '0;
            r_depth   <= '0;
            r_in_isr  <= 1'b0;
            r_irq_ack <= 1'b0;
            r_ovf     <= 1'b0;
            r_unf     <= 1'b0;
        end else begin
            r_irq_ack <= w_take_irq;
            r_pc      <= w_next_pc;
            if (w_push) begin
                r_wp <= w_wp_inc;
                if (w_full) begin
                    r_ovf <= 1'b1;
                end else begin
                    r_depth <= r_depth + DW'(1);
                end
            end
            if (w_pop) begin
                if (w_empty) begin
                    r_unf <= 1'b1;
                end else begin
                    r_wp    <= w_wp_dec;
                    r_depth <= r_depth - DW'(1);
                end
            end
            if (w_take_irq) begin
                r_in_isr <= 1'b1;
            end else if (w_clr_isr) begin
                r_in_isr <= 1'b0;
            end
        end
    end

    // Stack storage is deliberately left out of reset; depth masks stale entries.
    always_ff @(posedge clk) begin
        if (!reset && w_push) begin
            r_mem[r_wp] <= w_push_val;
        end
    end

    assign bus.pc      = r_pc;
    assign bus.irq_ack = r_irq_ack;
    assign bus.in_isr  = r_in_isr;
    assign bus.depth   = r_depth;
    assign bus.ovf     = r_ovf;
    assign bus.unf     = r_unf;
endmodule

// File: tb/tb_pc_seq.sv
// Directed bench for pc_seq: reset, wrap, call/ret, overflow/underflow,
// interrupt entry/RETI, freeze and reset during an ISR.
module tb_pc_seq;
  logic clk;
  logic reset;
  int n_checks;
  int n_pass;

  pc_seq_if #(.AW(8), .DEPTH(4)) bus ();

  pc_seq #(.AW(8), .DEPTH(4), .RESET_VEC(8'h00), .IRQ_VEC(8'hF0)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.interrupt = 1'b0;
    bus.freeze    = 1'b0;
    bus.jump      = 1'b0;
    bus.call      = 1'b0;
    bus.ret       = 1'b0;
    bus.reti      = 1'b0;
    bus.jump_addr = 8'h00;
  endtask

  task automatic do_reset();
    idle();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic do_jump(input logic [7:0] a);
    idle();
    bus.jump = 1'b1;
    bus.jump_addr = a;
    tick();
    idle();
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++; if (bus.pc !== 8'h00) $display("FAIL rst_pc: got %h expected 00", bus.pc); else n_pass++;
    n_checks++; if (bus.depth !== 3'd0) $display("FAIL rst_depth: got %0d expected 0", bus.depth); else n_pass++;
    n_checks++; if (bus.in_isr !== 1'b0) $display("FAIL rst_in_isr: got %b expected 0", bus.in_isr); else n_pass++;
    n_checks++; if (bus.irq_ack !== 1'b0) $display("FAIL rst_irq_ack: got %b expected 0", bus.irq_ack); else n_pass++;
    n_checks++; if ({bus.ovf, bus.unf} !== 2'b00) $display("FAIL rst_flags: got %b expected 00", {bus.ovf, bus.unf}); else n_pass++;
    for (int i = 1; i <= 3; i++) begin
      tick();
      n_checks++; if (bus.pc !== 8'(i)) $display("FAIL idle_pc%0d: got %h expected %h", i, bus.pc, 8'(i)); else n_pass++;
    end
  endtask

  task automatic test_wrap();
    do_jump(8'hFF);
    n_checks++; if (bus.pc !== 8'hFF) $display("FAIL wrap_jump: got %h expected ff", bus.pc); else n_pass++;
    tick();
    n_checks++; if (bus.pc !== 8'h00) $display("FAIL wrap_pc: got %h expected 00", bus.pc); else n_pass++;
    n_checks++; if ({bus.ovf, bus.unf, bus.irq_ack} !== 3'b000) $display("FAIL wrap_flags: got %b expected 000", {bus.ovf, bus.unf, bus.irq_ack}); else n_pass++;
  endtask

  task automatic test_call_ret();
    logic [7:0] exp_pc [4];
    logic [2:0] exp_d [4];
    exp_pc[0] = 8'h40; exp_pc[1] = 8'h80; exp_pc[2] = 8'h41; exp_pc[3] = 8'h11;
    exp_d[0] = 3'd1; exp_d[1] = 3'd2; exp_d[2] = 3'd1; exp_d[3] = 3'd0;
    do_jump(8'h10);
    for (int i = 0; i < 4; i++) begin
      idle();
      if (i == 0) begin bus.call = 1'b1; bus.jump_addr = 8'h40; end
      else if (i == 1) begin bus.call = 1'b1; bus.jump_addr = 8'h80; end
      else bus.ret = 1'b1;
      tick();
      n_checks++; if (bus.pc !== exp_pc[i]) $display("FAIL cr_pc%0d: got %h expected %h", i, bus.pc, exp_pc[i]); else n_pass++;
      n_checks++; if (bus.depth !== exp_d[i]) $display("FAIL cr_depth%0d: got %0d expected %0d", i, bus.depth, exp_d[i]); else n_pass++;
    end
    idle();
  endtask

  task automatic test_overflow_underflow();
    logic [7:0] exp_pc [5];
    do_reset();
    for (int i = 1; i <= 5; i++) begin
      idle();
      bus.call = 1'b1;
      bus.jump_addr = 8'(i);
      tick();
      n_checks++; if (bus.pc !== 8'(i)) $display("FAIL ovf_call_pc%0d: got %h expected %h", i, bus.pc, 8'(i)); else n_pass++;
      n_checks++; if (bus.ovf !== (i == 5)) $display("FAIL ovf_flag%0d: got %b expected %b", i, bus.ovf, (i == 5)); else n_pass++;
    end
    n_checks++; if (bus.depth !== 3'd4) $display("FAIL ovf_depth: got %0d expected 4", bus.depth); else n_pass++;
    // Oldest entry (01) was overwritten; the 5th pop underflows and increments from 02.
    exp_pc[0] = 8'h05; exp_pc[1] = 8'h04; exp_pc[2] = 8'h03; exp_pc[3] = 8'h02; exp_pc[4] = 8'h03;
    for (int i = 0; i < 5; i++) begin
      idle();
      bus.ret = 1'b1;
      tick();
      n_checks++; if (bus.pc !== exp_pc[i]) $display("FAIL unf_ret_pc%0d: got %h expected %h", i, bus.pc, exp_pc[i]); else n_pass++;
      n_checks++; if (bus.unf !== (i == 4)) $display("FAIL unf_flag%0d: got %b expected %b", i, bus.unf, (i == 4)); else n_pass++;
    end
    idle();
    tick();
    n_checks++; if (bus.pc !== 8'h04) $display("FAIL unf_inc: got %h expected 04", bus.pc); else n_pass++;
    n_checks++; if ({bus.ovf, bus.unf, bus.depth} !== 5'b11000) $display("FAIL unf_sticky: got %b expected 11000", {bus.ovf, bus.unf, bus.depth}); else n_pass++;
  endtask

  task automatic test_interrupt();
    do_reset();
    do_jump(8'h20);
    bus.interrupt = 1'b1;
    bus.jump = 1'b1;
    bus.jump_addr = 8'h55;
    tick();
    bus.jump = 1'b0;
    n_checks++; if (bus.pc !== 8'hF0) $display("FAIL irq_pc: got %h expected f0", bus.pc); else n_pass++;
    n_checks++; if ({bus.irq_ack, bus.in_isr} !== 2'b11) $display("FAIL irq_ack_isr: got %b expected 11", {bus.irq_ack, bus.in_isr}); else n_pass++;
    n_checks++; if (bus.depth !== 3'd1) $display("FAIL irq_depth: got %0d expected 1", bus.depth); else n_pass++;
    for (int i = 1; i <= 3; i++) begin
      tick();
      n_checks++; if (bus.pc !== 8'hF0 + 8'(i)) $display("FAIL isr_pc%0d: got %h expected %h", i, bus.pc, 8'hF0 + 8'(i)); else n_pass++;
      n_checks++; if ({bus.irq_ack, bus.in_isr} !== 2'b01) $display("FAIL isr_noreentry%0d: got %b expected 01", i, {bus.irq_ack, bus.in_isr}); else n_pass++;
    end
    bus.reti = 1'b1;
    tick();
    bus.reti = 1'b0;
    n_checks++; if (bus.pc !== 8'h20) $display("FAIL reti_pc: got %h expected 20", bus.pc); else n_pass++;
    n_checks++; if ({bus.in_isr, bus.depth} !== 4'b0000) $display("FAIL reti_state: got %b expected 0000", {bus.in_isr, bus.depth}); else n_pass++;
    tick();
    n_checks++; if (bus.pc !== 8'hF0) $display("FAIL reentry_pc: got %h expected f0", bus.pc); else n_pass++;
    n_checks++; if ({bus.irq_ack, bus.in_isr} !== 2'b11) $display("FAIL reentry_ack: got %b expected 11", {bus.irq_ack, bus.in_isr}); else n_pass++;
    idle();
    bus.reti = 1'b1;
    tick();
    idle();
    n_checks++; if (bus.pc !== 8'h20) $display("FAIL reti2_pc: got %h expected 20", bus.pc); else n_pass++;
  endtask

  task automatic test_freeze();
    do_reset();
    do_jump(8'h33);
    bus.freeze = 1'b1;
    bus.interrupt = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++; if (bus.pc !== 8'h33) $display("FAIL frz_pc%0d: got %h expected 33", i, bus.pc); else n_pass++;
      n_checks++; if ({bus.irq_ack, bus.in_isr} !== 2'b00) $display("FAIL frz_irq%0d: got %b expected 00", i, {bus.irq_ack, bus.in_isr}); else n_pass++;
    end
    bus.freeze = 1'b0;
    tick();
    n_checks++; if (bus.pc !== 8'hF0) $display("FAIL frz_entry_pc: got %h expected f0", bus.pc); else n_pass++;
    n_checks++; if (bus.irq_ack !== 1'b1) $display("FAIL frz_entry_ack: got %b expected 1", bus.irq_ack); else n_pass++;
    idle();
    bus.reti = 1'b1;
    tick();
    idle();
    n_checks++; if (bus.pc !== 8'h33) $display("FAIL frz_stacked: got %h expected 33", bus.pc); else n_pass++;
  endtask

  task automatic test_reset_mid_isr();
    do_reset();
    bus.ret = 1'b1;
    tick();
    idle();
    n_checks++; if ({bus.pc, bus.unf} !== {8'h01, 1'b1}) $display("FAIL mid_unf: got %h/%b expected 01/1", bus.pc, bus.unf); else n_pass++;
    bus.call = 1'b1;
    bus.jump_addr = 8'h40;
    tick();
    idle();
    bus.interrupt = 1'b1;
    tick();
    n_checks++; if ({bus.pc, bus.depth, bus.in_isr} !== {8'hF0, 3'd2, 1'b1}) $display("FAIL mid_isr: got %h/%0d/%b expected f0/2/1", bus.pc, bus.depth, bus.in_isr); else n_pass++;
    bus.call = 1'b1;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    idle();
    n_checks++; if (bus.pc !== 8'h00) $display("FAIL mid_rst_pc: got %h expected 00", bus.pc); else n_pass++;
    n_checks++; if ({bus.depth, bus.in_isr, bus.irq_ack, bus.ovf, bus.unf} !== 7'b0) $display("FAIL mid_rst_state: got %b expected 0000000", {bus.depth, bus.in_isr, bus.irq_ack, bus.ovf, bus.unf}); else n_pass++;
    bus.ret = 1'b1;
    tick();
    idle();
    n_checks++; if ({bus.pc, bus.unf} !== {8'h01, 1'b1}) $display("FAIL mid_rst_nostack: got %h/%b expected 01/1", bus.pc, bus.unf); else n_pass++;
  endtask

  initial begin
    n_checks = 0;
    n_pass = 0;
    reset = 1'b1;
    idle();
    test_reset();
    test_wrap();
    test_call_ret();
    test_overflow_underflow();
    test_interrupt();
    test_freeze();
    test_reset_mid_isr();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
